// File: rtl/dmem_arbiter.sv
// Two-requester (core / DMA) round-robin arbiter onto a single-word data memory.
// Vector requests are split into six sequential word beats and gathered back into one wide result.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int S    = 32,
  parameter int V    = 192,
  parameter int SIZE = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         c_req,
  input  logic         c_we,
  input  logic         c_vec,
  input  logic [S-1:0] c_addr,
  input  logic [V-1:0] c_wd,
  output logic         c_gnt,
  output logic         c_done,
  output logic         c_err,
  output logic [V-1:0] c_rd,
  input  logic         d_req,
  input  logic         d_we,
  input  logic         d_vec,
  input  logic [S-1:0] d_addr,
  input  logic [V-1:0] d_wd,
  output logic         d_gnt,
  output logic         d_done,
  output logic         d_err,
  output logic [V-1:0] d_rd,
  output logic         mem_we,
  output logic [S-1:0] mem_addr,
  output logic [S-1:0] mem_wd,
  input  logic [S-1:0] mem_rd,
  output logic         busy
);

  localparam int LANES = V / S;
  localparam int BW    = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

  state_t         state;
  state_t         state_nx;
  logic           ptr;
  logic           owner;
  logic           we_q;
  logic           vec_q;
  logic           err_q;
  logic [BW-1:0]  beat;
  logic [S-1:0]   addr_q;
  logic [V-1:0]   wd_q;
  logic [V-1:0]   rbuf_q;
  logic [V-1:0]   c_rd_q;
  logic [V-1:0]   d_rd_q;
  logic           c_err_q;
  logic           d_err_q;

  logic           grant;
  logic           win;
  logic           sel_we;
  logic           sel_vec;
  logic           sel_err;
  logic [S-1:0]   sel_addr;
  logic [V-1:0]   sel_wd;
  logic [S:0]     sel_end;
  logic           last_beat;
  logic [V-1:0]   rd_final;

  // ptr/win/owner: 0 = core, 1 = DMA
  always_comb begin
    grant = 1'b0;
    win   = 1'b0;
    if (state == IDLE && !rst) begin
      if (c_req && d_req) begin
        grant = 1'b1;
        win   = ptr;
      end else if (c_req) begin
        grant = 1'b1;
        win   = 1'b0;
      end else if (d_req) begin
        grant = 1'b1;
        win   = 1'b1;
      end
    end
  end

  assign sel_we   = win ? d_we   : c_we;
  assign sel_vec  = win ? d_vec  : c_vec;
  assign sel_addr = win ? d_addr : c_addr;
  assign sel_wd   = win ? d_wd   : c_wd;

  // One extra bit so addr + N cannot wrap and sneak under the bound.
  assign sel_end  = {1'b0, sel_addr} + (sel_vec ? (S+1)'(LANES) : (S+1)'(1));
  assign sel_err  = sel_end > (S+1)'(SIZE);

  assign last_beat = vec_q ? (beat == BW'(LANES - 1)) : (beat == '0);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (grant) state_nx = sel_err ? DONE : BEAT;
      BEAT: if (last_beat) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      owner   <= 1'b0;
      we_q    <= 1'b0;
      vec_q   <= 1'b0;
      err_q   <= 1'b0;
      beat    <= '0;
      c_rd_q  <= '0;
      d_rd_q  <= '0;
      c_err_q <= 1'b0;
      d_err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant) begin
        ptr   <= ~win;
        owner <= win;
        we_q  <= sel_we;
        vec_q <= sel_vec;
        err_q <= sel_err;
        beat  <= '0;
      end else if (state == BEAT && !last_beat) begin
        beat <= beat + 1'b1;
      end
      if (state == DONE) begin
        if (owner) begin
          d_rd_q  <= rd_final;
          d_err_q <= err_q;
        end else begin
          c_rd_q  <= rd_final;
          c_err_q <= err_q;
        end
      end
    end
  end

  // Read word for beat i arrives during beat i+1, so lane beat-1 is captured here.
  always_ff @(posedge clk) begin
    if (grant) begin
      addr_q <= sel_addr;
      wd_q   <= sel_wd;
      rbuf_q <= '0;
    end else if (state == BEAT && beat != '0) begin
      rbuf_q[S*(int'(beat) - 1) +: S] <= mem_rd;
    end
  end

  // The final lane lands during DONE and is forwarded straight to the owner.
  always_comb begin
    rd_final = rbuf_q;
    if (vec_q) rd_final[S*(LANES-1) +: S] = mem_rd;
    else       rd_final[S-1:0]            = mem_rd;
    if (err_q || we_q) rd_final = '0;
  end

  assign c_gnt  = grant & ~win;
  assign d_gnt  = grant & win;
  assign c_done = (state == DONE) && !owner;
  assign d_done = (state == DONE) && owner;
  assign c_rd   = c_done ? rd_final : c_rd_q;
  assign d_rd   = d_done ? rd_final : d_rd_q;
  assign c_err  = c_done ? err_q : c_err_q;
  assign d_err  = d_done ? err_q : d_err_q;
  assign busy   = (state != IDLE);

  assign mem_we   = (state == BEAT) && we_q;
  assign mem_addr = (state == BEAT) ? (addr_q + {{(S-BW){1'b0}}, beat}) : '0;
  assign mem_wd   = mem_we ? wd_q[S*int'(beat) +: S] : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural single-word memory plus hand-computed expectations.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int S = 32;
  localparam int V = 192;

  logic         clk = 1'b0;
  logic         rst;
  logic         c_req, c_we, c_vec;
  logic [S-1:0] c_addr;
  logic [V-1:0] c_wd;
  logic         c_gnt, c_done, c_err;
  logic [V-1:0] c_rd;
  logic         d_req, d_we, d_vec;
  logic [S-1:0] d_addr;
  logic [V-1:0] d_wd;
  logic         d_gnt, d_done, d_err;
  logic [V-1:0] d_rd;
  logic         mem_we;
  logic [S-1:0] mem_addr, mem_wd;
  logic [S-1:0] mem_rd;
  logic         busy;

  logic [S-1:0] mem [0:15];

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  localparam logic [V-1:0] VEC = {32'h15, 32'h14, 32'h13, 32'h12, 32'h11, 32'h10};
  localparam logic [V-1:0] VEC2 = {32'hF5, 32'hF4, 32'hF3, 32'hF2, 32'hF1, 32'hF0};

  dmem_arbiter #(.S(S), .V(V), .SIZE(14)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_vec(c_vec), .c_addr(c_addr), .c_wd(c_wd),
    .c_gnt(c_gnt), .c_done(c_done), .c_err(c_err), .c_rd(c_rd),
    .d_req(d_req), .d_we(d_we), .d_vec(d_vec), .d_addr(d_addr), .d_wd(d_wd),
    .d_gnt(d_gnt), .d_done(d_done), .d_err(d_err), .d_rd(d_rd),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous memory: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (mem_we && mem_addr < 16) mem[mem_addr[3:0]] <= mem_wd;
    mem_rd <= (mem_addr < 16) ? mem[mem_addr[3:0]] : '0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [V-1:0] obs, input logic [V-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_vec = 1'b0; c_addr = '0; c_wd = '0;
    d_req = 1'b1; d_we = 1'b0; d_vec = 1'b0; d_addr = '0; d_wd = '0;
    step();
    step();
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wd", mem_wd, 0);
    chk("rst_c_rd", c_rd, 0);
    chk("rst_d_rd", d_rd, 0);
    chk("rst_done", {c_done, d_done, c_err, d_err}, 0);
    c_req = 1'b0; d_req = 1'b0; rst = 1'b0;
    step();

    // core scalar write addr 3
    c_req = 1'b1; c_we = 1'b1; c_vec = 1'b0; c_addr = 3; c_wd = {160'h0, 32'hDEADBEEF};
    #1;
    chk("w1_c_gnt", c_gnt, 1);
    chk("w1_d_gnt", d_gnt, 0);
    step();
    c_req = 1'b0; c_we = 1'b0; c_wd = '0;
    chk("w1_mem_we", mem_we, 1);
    chk("w1_mem_addr", mem_addr, 3);
    chk("w1_mem_wd", mem_wd, 32'hDEADBEEF);
    chk("w1_busy", busy, 1);
    chk("w1_done_early", c_done, 0);
    step();
    chk("w1_c_done", c_done, 1);
    chk("w1_c_err", c_err, 0);
    chk("w1_mem_we_done", mem_we, 0);
    step();
    chk("w1_idle", {busy, c_done}, 0);

    // DMA vector write addr 4..9
    d_req = 1'b1; d_we = 1'b1; d_vec = 1'b1; d_addr = 4; d_wd = VEC;
    #1;
    chk("vw_d_gnt", d_gnt, 1);
    step();
    d_req = 1'b0; d_we = 1'b0; d_vec = 1'b0; d_wd = '0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("vw_we%0d", i), mem_we, 1);
      chk($sformatf("vw_addr%0d", i), mem_addr, 4 + i);
      chk($sformatf("vw_wd%0d", i), mem_wd, 32'h10 + i);
      step();
    end
    chk("vw_d_done", d_done, 1);
    chk("vw_d_err", d_err, 0);
    step();
    chk("vw_idle", busy, 0);

    // DMA vector read addr 4..9
    d_req = 1'b1; d_we = 1'b0; d_vec = 1'b1; d_addr = 4;
    #1;
    chk("vr_d_gnt", d_gnt, 1);
    step();
    d_req = 1'b0; d_vec = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("vr_addr%0d", i), mem_addr, 4 + i);
      chk($sformatf("vr_we%0d", i), mem_we, 0);
      chk($sformatf("vr_nodone%0d", i), d_done, 0);
      step();
    end
    chk("vr_d_done", d_done, 1);
    chk("vr_d_rd", d_rd, VEC);
    chk("vr_d_err", d_err, 0);
    chk("vr_c_done", c_done, 0);
    step();
    chk("vr_d_rd_hold", d_rd, VEC);
    chk("vr_d_done_pulse", d_done, 0);

    // core scalar write word 0, then core vector read, then core scalar read word 0
    c_req = 1'b1; c_we = 1'b1; c_vec = 1'b0; c_addr = 0; c_wd = {160'h0, 32'hCAFE0001};
    step();
    c_req = 1'b0; c_we = 1'b0;
    step();
    chk("w0_c_done", c_done, 1);
    step();
    c_req = 1'b1; c_we = 1'b0; c_vec = 1'b1; c_addr = 4;
    #1;
    chk("cvr_c_gnt", c_gnt, 1);
    step();
    c_req = 1'b0; c_vec = 1'b0;
    repeat (6) step();
    chk("cvr_c_done", c_done, 1);
    chk("cvr_c_rd", c_rd, VEC);
    step();
    c_req = 1'b1; c_we = 1'b0; c_vec = 1'b0; c_addr = 0;
    step();
    c_req = 1'b0;
    chk("sr_mem_addr", mem_addr, 0);
    step();
    chk("sr_c_done", c_done, 1);
    chk("sr_c_rd", c_rd, {160'h0, 32'hCAFE0001});
    chk("sr_d_rd_kept", d_rd, VEC);
    step();

    // core vector write addr 9 is out of bounds
    c_req = 1'b1; c_we = 1'b1; c_vec = 1'b1; c_addr = 9; c_wd = VEC2;
    #1;
    chk("oob_c_gnt", c_gnt, 1);
    step();
    c_req = 1'b0; c_we = 1'b0; c_vec = 1'b0;
    chk("oob_c_done", c_done, 1);
    chk("oob_c_err", c_err, 1);
    chk("oob_c_rd", c_rd, 0);
    chk("oob_mem_we", mem_we, 0);
    chk("oob_busy", busy, 1);
    step();
    chk("oob_idle", busy, 0);
    chk("oob_err_hold", c_err, 1);
    chk("oob_done_pulse", c_done, 0);

    // DMA vector read addr 8 ends exactly at SIZE: legal
    d_req = 1'b1; d_we = 1'b0; d_vec = 1'b1; d_addr = 8;
    #1;
    chk("edge_d_gnt", d_gnt, 1);
    step();
    d_req = 1'b0; d_vec = 1'b0;
    chk("edge_mem_addr", mem_addr, 8);
    repeat (6) step();
    chk("edge_d_done", d_done, 1);
    chk("edge_d_err", d_err, 0);
    chk("edge_c_err_kept", c_err, 1);
    step();

    // core scalar write addr 13 (last word) is legal and clears c_err
    c_req = 1'b1; c_we = 1'b1; c_vec = 1'b0; c_addr = 13; c_wd = {160'h0, 32'h0000_0D0D};
    step();
    c_req = 1'b0; c_we = 1'b0;
    chk("a13_mem_we", mem_we, 1);
    chk("a13_mem_addr", mem_addr, 13);
    step();
    chk("a13_c_done", c_done, 1);
    chk("a13_c_err", c_err, 0);
    step();

    // both requesters held from reset: core, DMA, core
    rst = 1'b1;
    #1;
    chk("rr_rst_busy", busy, 0);
    step();
    rst = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_vec = 1'b0; c_addr = 0;
    d_req = 1'b1; d_we = 1'b0; d_vec = 1'b0; d_addr = 3;
    #1;
    chk("rr0_c_gnt", c_gnt, 1);
    chk("rr0_d_gnt", d_gnt, 0);
    step();
    chk("rr1_d_gnt", d_gnt, 0);
    chk("rr1_busy", busy, 1);
    step();
    chk("rr2_d_gnt", d_gnt, 0);
    chk("rr2_c_done", c_done, 1);
    step();
    chk("rr3_d_gnt", d_gnt, 1);
    chk("rr3_c_gnt", c_gnt, 0);
    step();
    chk("rr4_c_gnt", c_gnt, 0);
    step();
    chk("rr5_d_done", d_done, 1);
    chk("rr5_d_rd", d_rd, {160'h0, 32'hDEADBEEF});
    chk("rr5_c_gnt", c_gnt, 0);
    step();
    chk("rr6_c_gnt", c_gnt, 1);
    chk("rr6_d_gnt", d_gnt, 0);
    step();
    c_req = 1'b0; d_req = 1'b0;
    step();
    step();

    // reset during beat 3 of a core vector write
    c_req = 1'b1; c_we = 1'b1; c_vec = 1'b1; c_addr = 0; c_wd = VEC2;
    step();
    c_req = 1'b0; c_we = 1'b0; c_vec = 1'b0;
    step();
    step();
    step();
    chk("ra_mem_we_b3", mem_we, 1);
    chk("ra_mem_addr_b3", mem_addr, 3);
    chk("ra_mem_wd_b3", mem_wd, 32'hF3);
    rst = 1'b1;
    #1;
    chk("ra_mem_we_rst", mem_we, 0);
    chk("ra_mem_addr_rst", mem_addr, 0);
    chk("ra_busy_rst", busy, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ra_no_we%0d", i), mem_we, 0);
      chk($sformatf("ra_no_done%0d", i), c_done, 0);
      step();
    end
    c_req = 1'b1; c_addr = 4;
    d_req = 1'b1; d_addr = 5;
    #1;
    chk("ra_c_gnt", c_gnt, 1);
    chk("ra_d_gnt", d_gnt, 0);
    step();
    c_req = 1'b0; d_req = 1'b0;
    step();
    chk("ra_c_rd", c_rd, {160'h0, 32'h10});
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
